rf_arbiter: RTL
===============

# rf_arbiter

Two-requester controller for the 8 x 32-bit single-write/single-read register file. Two masters (A and B) each issue one read or write transaction at a time through a req/ack handshake. The arbiter selects one requester and drives the register file's we/wAddr/wData/rAddr for exactly one access cycle. It then returns read data and ack to the winner. The arbiter sits between the masters and the register file instance, and it is the only driver of the register file ports.

## Interface
- ADDR_W, 3, register address width (8 entries)
- DATA_W, 32, data width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  transaction request, held until ack
- wr_a / wr_b  in  1  1 = write, 0 = read; stable while req high
- addr_a / addr_b  in  ADDR_W  target register
- wdata_a / wdata_b  in  DATA_W  write data (ignored on read)
- ack_a / ack_b  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result, valid while ack_a or ack_b is high
- rf_we  out  1  register file write enable
- rf_waddr, rf_raddr  out  ADDR_W  register file addresses
- rf_wdata  out  DATA_W  register file write data
- rf_rdata  in  DATA_W  register file combinational read data

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE. All rf_* outputs hold 0.
- IDLE, any request: choose a winner, then latch its wr/addr/wdata and an owner bit. Next state is ACCESS.
  - Only one request high: that requester wins.
  - Both requests high: the requester not served last wins (round-robin).
- ACCESS (exactly one cycle), write: rf_we = 1, rf_waddr = latched address, rf_wdata = latched data.
- ACCESS, read: rf_we = 0, rf_raddr = latched address. rf_rdata is captured into the rdata register at the closing edge.
- ACCESS always transitions to RESP.
- RESP: ack of the owner is 1 for one cycle and rdata holds its value. For writes, rdata = 0. The last-served pointer is updated to the owner. Next state is IDLE.
- Requester rule: deassert req on the edge that samples ack = 1. A req still high in the following IDLE cycle is treated as a new transaction.
- A losing requester keeps req high. It wins on the next IDLE if the other requester is idle or was served last.
- rf_we is never 1 outside ACCESS. rf_raddr and rf_waddr return to 0 outside ACCESS.
- Address wrap: none. ADDR_W bits address all 8 entries, and 7 is valid.

## Timing
- Reset values: state IDLE, ack_a = ack_b = 0, rdata = 0, rf_we = 0, rf_waddr = rf_raddr = 0, rf_wdata = 0, last-served = B (so A wins the first tie).
- Latency: req sampled high at edge N → ACCESS during cycle N..N+1 → ack high between edges N+1 and N+2.
- Throughput: one transaction per 3 cycles, including the mandatory IDLE cycle.
- All outputs are registered. No combinational path from req to rf_* or ack.
- Asynchronous reset mid-ACCESS: rf_we drops immediately. Any write not completed at reset is lost. No ack is issued.
- Simultaneous requests in the same IDLE cycle: exactly one is granted, and the other waits at least 3 cycles.

## Configuration
- RF_ARB_FIXED_PRIO_EN defined: fixed priority, A always beats B on a tie. The last-served pointer is not implemented. B can starve while A requests continuously.
- RF_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Structure
- Package rf_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State encoding constants: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10.
  - Owner encoding: OWN_A = 1'b0, OWN_B = 1'b1.
- One sub-module, rr_arb2: a 2-way round-robin picker holding the last-served flop. Its inputs are two requests and an update strobe, and its output is a one-hot grant.
- rr_arb2 is replaced by a constant grant under RF_ARB_FIXED_PRIO_EN.
- The register file itself is instantiated by the parent, not inside rf_arbiter.

## Test plan
- Reset then idle: reset_n = 0 for 7 ns, then 1, no requests → rf_we = 0, ack_a = ack_b = 0, rdata = 0 for 10 cycles.
- Write then read, single requester: A writes 32'h11111111 to address 1, then reads address 1 → ack_a pulses twice, 3 cycles apart, and the second rdata = 32'h11111111.
- Tie after reset: A and B both request in the same cycle (A writes 32'hff00ff00 to address 2, B writes 32'h00ff00ff to address 3) → A is acked first, B 3 cycles later; reading addresses 2 and 3 returns those values.
- Fairness: A and B hold req continuously (reads of addresses 0 and 7) → acks alternate A, B, A, B. With RF_ARB_FIXED_PRIO_EN defined → A only, B never acked.
- Reset mid-ACCESS: assert reset_n = 0 while rf_we = 1 → rf_we = 0 immediately, state IDLE, no ack; after release, the next request is served normally.
- Hold check: B requests a write while A is in ACCESS → B is not granted until the next IDLE, and rf_we is high for exactly one cycle per transaction.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared widths, FSM encoding and owner encoding for the register-file arbiter.
package rf_arb_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
endpackage

// File: rtl/rf_arbiter_if.sv
// Master-side req/ack bus plus register-file port bundle for rf_arbiter.
interface rf_arbiter_if;
  import rf_arb_pkg::*;

  logic              req_a,   req_b;
  logic              wr_a,    wr_b;
  logic [ADDR_W-1:0] addr_a,  addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              ack_a,   ack_b;
  logic [DATA_W-1:0] rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr, rf_raddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  // requesters and register file sit on the master side
  modport master (
    output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b, rf_rdata,
    input  ack_a, ack_b, rdata, rf_we, rf_waddr, rf_raddr, rf_wdata
  );

  modport slave (
    input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b, rf_rdata,
    output ack_a, ack_b, rdata, rf_we, rf_waddr, rf_raddr, rf_wdata
  );
endinterface

// File: rtl/rf_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; last-served flop resets to B so A wins the first tie.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reqA,
  input  logic       reqB,
  input  logic       upd,
  input  logic       updOwner,
  output logic [1:0] gnt
);
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= OWN_B;
    else if (upd) last <= updOwner;
  end

  always_comb begin
    gnt = 2'b00;
    if (reqA && (!reqB || last == OWN_B)) gnt = 2'b01;
    else if (reqB)                         gnt = 2'b10;
  end
endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: two-master req/ack controller for an 8x32 register file, IDLE/ACCESS/RESP FSM.
// Define RF_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module rf_arbiter
  import rf_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  rf_arbiter_if.slave bus
);
  state_t            state, stateNxt;
  logic [1:0]        gnt;
  logic              owner, wrQ;
  logic              winOwner, winWr;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winWdata;

  logic              rfWe, ackA, ackB;
  logic [ADDR_W-1:0] rfWaddr, rfRaddr;
  logic [DATA_W-1:0] rfWdata, rdataQ;

`ifdef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (bus.req_a)      gnt = 2'b01;
    else if (bus.req_b) gnt = 2'b10;
  end
`else
  rr_arb2 uArb (
    .clk      (clk),
    .rst_n    (reset_n),
    .reqA     (bus.req_a),
    .reqB     (bus.req_b),
    .upd      (state == RESP),
    .updOwner (owner),
    .gnt      (gnt)
  );
`endif

  assign winOwner = gnt[1] ? OWN_B       : OWN_A;
  assign winWr    = gnt[1] ? bus.wr_b    : bus.wr_a;
  assign winAddr  = gnt[1] ? bus.addr_b  : bus.addr_a;
  assign winWdata = gnt[1] ? bus.wdata_b : bus.wdata_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (|gnt) stateNxt = ACCESS;
      ACCESS:  stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // rf_* are loaded on the IDLE->ACCESS edge so they are registered and live only during ACCESS
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWN_A;
      wrQ     <= 1'b0;
      rfWe    <= 1'b0;
      rfWaddr <= '0;
      rfRaddr <= '0;
      rfWdata <= '0;
      rdataQ  <= '0;
      ackA    <= 1'b0;
      ackB    <= 1'b0;
    end else begin
      ackA <= 1'b0;
      ackB <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            owner <= winOwner;
            wrQ   <= winWr;
            rfWe  <= winWr;
            if (winWr) begin
              rfWaddr <= winAddr;
              rfWdata <= winWdata;
            end else begin
              rfRaddr <= winAddr;
            end
          end
        end
        ACCESS: begin
          rfWe    <= 1'b0;
          rfWaddr <= '0;
          rfRaddr <= '0;
          rfWdata <= '0;
          rdataQ  <= wrQ ? '0 : bus.rf_rdata;
          ackA    <= (owner == OWN_A);
          ackB    <= (owner == OWN_B);
        end
        default: ;
      endcase
    end
  end

  assign bus.rf_we    = rfWe;
  assign bus.rf_waddr = rfWaddr;
  assign bus.rf_raddr = rfRaddr;
  assign bus.rf_wdata = rfWdata;
  assign bus.rdata    = rdataQ;
  assign bus.ack_a    = ackA;
  assign bus.ack_b    = ackB;
endmodule
